// File: rtl/uart_boot_loader.sv
// UART boot loader: takes a framed program image from the UART byte stream, writes it into
// Program_Mem word by word, then releases rv32i_core. Also arbitrates the Program_Mem address.
module uart_boot_loader #(
  parameter int unsigned ADDR_W   = 14,
  parameter logic [7:0]  MAGIC    = 8'hA5,
  parameter int unsigned TIMEOUT  = 65536,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rstB,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              boot_req,
  input  logic              skip_boot,
  input  logic [31:0]       core_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_din,
  output logic              core_rstB,
  output logic              core_clkEn,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);
  localparam int unsigned WIDX_W    = ADDR_W - 2;
  localparam int unsigned IDLE_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [16:0] MAX_WORDS = 17'(2 ** WIDX_W);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_LEN     = 2'd3;

  typedef enum logic [2:0] {
    S_WAIT_MAGIC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RELEASE, S_RUN, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          err_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         n_q, n_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         din_d;
  logic                we_d, done_d, busy_d, rstb_d, clken_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                in_frame;
  logic                sel_core;
  logic                unused_pc_hi;

  assign in_frame     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
  assign sel_core     = (state_q == S_RELEASE) || (state_q == S_RUN);
  assign mem_addr     = sel_core ? core_pc[ADDR_W-1:0] : addr_q;
  assign unused_pc_hi = ^core_pc[31:ADDR_W];

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    err_d    = err;
    sum_d    = sum_q;
    len_lo_d = len_lo_q;
    n_d      = n_q;
    widx_d   = widx_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    addr_d   = addr_q;
    din_d    = mem_din;
    we_d     = 1'b0;
    done_d   = 1'b0;
    hold_d   = hold_q;
    idle_d   = in_frame ? idle_q + IDLE_W'(1) : '0;
    if (rx_valid) idle_d = '0;

    case (state_q)
      S_WAIT_MAGIC: begin
        if (skip_boot) begin
          state_d = S_RELEASE;
          hold_d  = '0;
        end else if (rx_valid && rx_data == MAGIC) begin
          state_d = S_LEN_LO;
          err_d   = ERR_NONE;
          sum_d   = '0;
        end
      end
      S_LEN_LO: if (rx_valid) begin
        len_lo_d = rx_data;
        sum_d    = sum_q + rx_data;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (rx_valid) begin
        sum_d = sum_q + rx_data;
        n_d   = {rx_data, len_lo_q};
        if (17'({rx_data, len_lo_q}) > MAX_WORDS) begin
          state_d = S_ERROR;
          err_d   = ERR_LEN;
        end else if ({rx_data, len_lo_q} == 16'd0) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
          widx_d  = '0;
          bcnt_d  = '0;
        end
      end
      S_DATA: if (rx_valid) begin
        sum_d  = sum_q + rx_data;
        bcnt_d = bcnt_q + 2'd1;
        case (bcnt_q)
          2'd0:    word_d[7:0]   = rx_data;
          2'd1:    word_d[15:8]  = rx_data;
          2'd2:    word_d[23:16] = rx_data;
          default: begin
            we_d   = 1'b1;
            addr_d = {widx_q, 2'b00};
            din_d  = {rx_data, word_q};
            widx_d = widx_q + WIDX_W'(1);
            if (17'(widx_q) + 17'd1 == 17'(n_q)) state_d = S_CSUM;
          end
        endcase
      end
      S_CSUM: if (rx_valid) begin
        if (rx_data == sum_q) begin
          state_d = S_RELEASE;
          done_d  = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = S_ERROR;
          err_d   = ERR_CSUM;
        end
      end
      S_RELEASE: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(RST_HOLD - 1)) state_d = S_RUN;
      end
      S_RUN: ;
      S_ERROR: if (rx_valid && rx_data == MAGIC) begin
        state_d = S_LEN_LO;
        err_d   = ERR_NONE;
        sum_d   = '0;
      end
      default: state_d = S_WAIT_MAGIC;
    endcase

    // A byte arriving on the expiry cycle is taken instead of timing out
    if (in_frame && !rx_valid && idle_q == IDLE_W'(TIMEOUT - 1)) begin
      state_d = S_ERROR;
      err_d   = ERR_TIMEOUT;
    end

    // boot_req aborts everything and drops any coincident byte
    if (boot_req && state_q != S_WAIT_MAGIC) begin
      state_d = S_WAIT_MAGIC;
      err_d   = err;
      we_d    = 1'b0;
      done_d  = 1'b0;
    end

    if (state_d != state_q) idle_d = '0;

    busy_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
              (state_d == S_DATA)   || (state_d == S_CSUM);
    rstb_d  = (state_d == S_RUN);
    clken_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      state_q    <= S_WAIT_MAGIC;
      err        <= ERR_NONE;
      sum_q      <= '0;
      len_lo_q   <= '0;
      n_q        <= '0;
      widx_q     <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      core_rstB  <= 1'b0;
      core_clkEn <= 1'b0;
      hold_q     <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      err        <= err_d;
      sum_q      <= sum_d;
      len_lo_q   <= len_lo_d;
      n_q        <= n_d;
      widx_q     <= widx_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      mem_din    <= din_d;
      mem_we     <= we_d;
      done       <= done_d;
      busy       <= busy_d;
      core_rstB  <= rstb_d;
      core_clkEn <= clken_d;
      hold_q     <= hold_d;
      idle_q     <= idle_d;
    end
  end

endmodule
